// File: rtl/usb3_pkg.sv
// usb3_pkg: shared FSM state type and default sizing
// for the FTDI USB3 receive burst interface.
package usb3_pkg;

  localparam int USB3_DATA_W     = 32;
  localparam int USB3_SKID_DEPTH = 4;
  localparam int USB3_MAX_BURST  = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OE_WAIT = 2'd1,
    READ    = 2'd2
  } usb3_state_e;

endpackage

// File: rtl/usb3_skid_fifo.sv
// usb3_skid_fifo: small power-of-2 FIFO absorbing the
// words captured after the read strobe is withdrawn.
module usb3_skid_fifo
  import usb3_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = USB3_SKID_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] FULL_CNT = AW1'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rp_q];

  // a pop frees the slot in the same cycle, so full+pop still accepts
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push}
                     - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/usb3_rx_burst_if.sv
// usb3_rx_burst_if: FTDI 245-style synchronous read burst
// engine feeding a downstream FIFO through a skid buffer.
module usb3_rx_burst_if
  import usb3_pkg::*;
#(
  parameter int DATA_W     = USB3_DATA_W,
  parameter int BE_W       = DATA_W / 8,
  parameter int SKID_DEPTH = USB3_SKID_DEPTH,
  parameter int MAX_BURST  = USB3_MAX_BURST
) (
  input  logic              ftdi_clk,
  input  logic              reset_n,
  input  logic              FT_RXF,
  output logic              FT_OE,
  output logic              FT_RD,
  input  logic [DATA_W-1:0] usb3_data_in,
  input  logic [BE_W-1:0]   usb3_be_in,
  output logic              fifo_wr,
  output logic [DATA_W-1:0] fifo_data,
  output logic [BE_W-1:0]   fifo_be,
  input  logic              fifo_full,
  output logic [31:0]       word_count,
  output logic              overflow_err
);

  localparam int CW  = $clog2(SKID_DEPTH) + 1;
  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam int EW  = DATA_W + BE_W;
  localparam logic [CW-1:0]  MARK = CW'(SKID_DEPTH - 2);
  localparam logic [BCW-1:0] BMAX = BCW'(MAX_BURST);

  usb3_state_e       state_q, state_d;
  logic              oe_q, rd_q;
  logic [BCW-1:0]    burst_q, burst_d;
  logic [31:0]       wcnt_q;
  logic              ovf_q;
  logic              wr_q;
  logic [DATA_W-1:0] data_q;
  logic [BE_W-1:0]   be_q;

  logic              cap, push, pop;
  logic              sk_full, sk_empty;
  logic [CW-1:0]     occ;
  logic [EW-1:0]     sk_out;

  assign cap  = ~rd_q & ~FT_RXF;
  assign push = cap & (|usb3_be_in);
  assign pop  = ~sk_empty & ~fifo_full;

  usb3_skid_fifo #(
    .WIDTH (EW),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk_i   (ftdi_clk),
    .rst_ni  (reset_n),
    .push_i  (push),
    .data_i  ({usb3_be_in, usb3_data_in}),
    .pop_i   (pop),
    .data_o  (sk_out),
    .full_o  (sk_full),
    .empty_o (sk_empty),
    .count_o (occ)
  );

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    unique case (state_q)
      IDLE: begin
        burst_d = '0;
        if (!FT_RXF && occ <= MARK && !fifo_full)
          state_d = OE_WAIT;
      end
      OE_WAIT: state_d = READ;
      READ: begin
        if (cap && burst_q != BMAX)
          burst_d = burst_q + 1'b1;
        // exit-edge capture still lands: skid keeps 2 spare slots
        if (FT_RXF || burst_d == BMAX || occ >= MARK)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ftdi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      oe_q    <= 1'b1;
      rd_q    <= 1'b1;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      oe_q    <= (state_d == IDLE);
      rd_q    <= (state_d != READ);
      burst_q <= burst_d;
    end
  end

  always_ff @(posedge ftdi_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q   <= 1'b0;
      data_q <= '0;
      be_q   <= '0;
      wcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wr_q <= pop;
      if (pop) {be_q, data_q} <= sk_out;
      if (push) wcnt_q <= wcnt_q + 32'd1;
      if (push && sk_full && !pop) ovf_q <= 1'b1;
    end
  end

  assign FT_OE        = oe_q;
  assign FT_RD        = rd_q;
  assign fifo_wr      = wr_q;
  assign fifo_data    = data_q;
  assign fifo_be      = be_q;
  assign word_count   = wcnt_q;
  assign overflow_err = ovf_q;

endmodule
